// File: rtl/cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_arbiter
// Description : Round-robin arbiter merging I-side and D-side cacheline
//               requests onto a single physical memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_grant_d;
    logic [ADDR_WIDTH-1:0] r_lat_addr;
    logic [LINE_WIDTH-1:0] r_lat_wdata;
    logic                  r_lat_read;
    logic                  r_lat_write;

    logic                  w_d_req;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_busy;

    assign w_d_req = d_read | d_write;

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a conflict the side that was not served last wins.
                if (i_read && w_d_req) begin
                    if (r_last_grant_d) w_grant_i = 1'b1;
                    else                w_grant_d = 1'b1;
                end else if (i_read) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i) w_state_next = ST_SERVE_I;
                if (w_grant_d) w_state_next = ST_SERVE_D;
            end
            ST_SERVE_I: if (pmem_resp) w_state_next = ST_IDLE;
            ST_SERVE_D: if (pmem_resp) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_grant_d <= 1'b0;
            r_lat_addr     <= '0;
            r_lat_wdata    <= '0;
            r_lat_read     <= 1'b0;
            r_lat_write    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_i) begin
                r_lat_addr  <= i_address;
                r_lat_wdata <= '0;
                r_lat_read  <= 1'b1;
                r_lat_write <= 1'b0;
            end else if (w_grant_d) begin
                // A simultaneous read and write is treated as a write.
                r_lat_addr  <= d_address;
                r_lat_wdata <= d_wdata;
                r_lat_read  <= ~d_write;
                r_lat_write <= d_write;
            end
            if (pmem_resp && r_state == ST_SERVE_I) r_last_grant_d <= 1'b0;
            if (pmem_resp && r_state == ST_SERVE_D) r_last_grant_d <= 1'b1;
        end
    end

    assign w_busy       = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);
    assign pmem_address = r_lat_addr;
    assign pmem_wdata   = r_lat_wdata;
    assign pmem_read    = w_busy & r_lat_read;
    assign pmem_write   = w_busy & r_lat_write;

    assign i_resp  = (r_state == ST_SERVE_I) & pmem_resp;
    assign d_resp  = (r_state == ST_SERVE_D) & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_arbiter
// Description : Directed and randomized checks of cacheline_arbiter against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_address, d_address, pmem_address;
    logic          i_read, d_read, d_write, pmem_resp;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    cacheline_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the memory port and what transaction it carries.
    int            m_owner;      // 0 = nobody, 1 = I-side, 2 = D-side
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [LW-1:0] m_wdata;
    bit            m_prefer_d;   // side that wins the next conflict
    bit            e_i_resp, e_d_resp;
    int            n_i_served, n_d_served;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_owner    = 0;
        m_addr     = '0;
        m_wr       = 1'b0;
        m_wdata    = '0;
        m_prefer_d = 1'b1;
    endtask

    // Inputs for the cycle are already applied; check outputs, then advance the model.
    task automatic step();
        bit d_req;
        #1;
        e_i_resp = (m_owner == 1) && pmem_resp;
        e_d_resp = (m_owner == 2) && pmem_resp;
        chk("pmem_read",  pmem_read,  (m_owner != 0) && !m_wr);
        chk("pmem_write", pmem_write, (m_owner != 0) && m_wr);
        chk("i_resp",     i_resp,     e_i_resp);
        chk("d_resp",     d_resp,     e_d_resp);
        chk("i_rdata",    i_rdata,    e_i_resp ? pmem_rdata : '0);
        chk("d_rdata",    d_rdata,    e_d_resp ? pmem_rdata : '0);
        if (m_owner != 0) begin
            chk("pmem_address", pmem_address, m_addr);
            chk("pmem_wdata",   pmem_wdata,   m_wdata);
        end
        if (e_i_resp) n_i_served++;
        if (e_d_resp) n_d_served++;

        d_req = d_read || d_write;
        if (rst) begin
            model_reset();
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_prefer_d = (m_owner == 1);
                m_owner    = 0;
            end
        end else if (i_read && (!d_req || !m_prefer_d)) begin
            m_owner = 1;
            m_addr  = i_address;
            m_wr    = 1'b0;
            m_wdata = '0;
        end else if (d_req) begin
            m_owner = 2;
            m_addr  = d_address;
            m_wr    = d_write;
            m_wdata = d_wdata;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    endtask

    bit       i_pend, d_pend;
    bit [1:0] d_op;

    initial begin
        rst = 1'b1; i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        idle_inputs();
        n_i_served = 0; n_d_served = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        #1;
        chk("reset pmem_address", pmem_address, '0);
        chk("reset pmem_wdata",   pmem_wdata,   '0);

        // Single I read with a three-cycle memory latency.
        i_read = 1'b1; i_address = 32'h0000_0040;
        step();
        step(); step();
        pmem_resp = 1'b1; pmem_rdata = {32{8'hAA}};
        step();
        chk("i_side one line", i_rdata, '0);  // response cycle is over
        idle_inputs();
        step();

        // D write whose wdata changes mid-transaction.
        d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = {8{32'h1234_5678}};
        step();
        d_wdata = rnd_line(); d_address = $urandom;
        step(); step();
        pmem_resp = 1'b1; pmem_rdata = rnd_line();
        step();
        idle_inputs();
        step();

        // Conflict straight after reset: D first, then alternation.
        rst = 1'b1; step(); rst = 1'b0;
        n_i_served = 0; n_d_served = 0;
        i_read = 1'b1; d_read = 1'b1; i_address = 32'h100; d_address = 32'h200;
        step();
        pmem_resp = 1'b1;
        step();
        chk("first conflict winner D", n_d_served, 1);
        chk("first conflict loser I", n_i_served, 0);
        for (int t = 0; t < 4; t++) begin
            pmem_resp = 1'b0; step();
            pmem_resp = 1'b1; step();
        end
        chk("alternation I count", n_i_served, 2);
        chk("alternation D count", n_d_served, 3);
        idle_inputs(); step();

        // Simultaneous d_read and d_write acts as a write.
        d_read = 1'b1; d_write = 1'b1; d_wdata = rnd_line();
        step(); step();
        pmem_resp = 1'b1; step();
        idle_inputs(); step();

        // Reset while serving D, then a late response and a spurious one in IDLE.
        d_read = 1'b1; d_address = 32'h300;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        d_read = 1'b0; pmem_resp = 1'b1;
        step(); step();
        pmem_resp = 1'b0; step();

        // Randomized traffic with random latency, spurious responses and resets.
        i_pend = 0; d_pend = 0; d_op = 2'b01;
        for (int c = 0; c < 4000; c++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) i_pend = 1;
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_op   = 2'($urandom_range(1, 3));
            end
            i_read     = i_pend;
            d_read     = d_pend && d_op[0];
            d_write    = d_pend && d_op[1];
            i_address  = $urandom;
            d_address  = $urandom;
            d_wdata    = rnd_line();
            pmem_rdata = rnd_line();
            pmem_resp  = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            step();
            if (e_i_resp && $urandom_range(0, 3) != 0) i_pend = 0;
            if (e_d_resp && $urandom_range(0, 3) != 0) d_pend = 0;
        end
        rst = 1'b0; idle_inputs(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
